// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch / interrupt front end.
// Holds the default vector layout, the return opcode and the return-stack entry format.
package fetch_pkg;

   localparam logic [3:0]  DEF_RTI_OPC    = 4'b0011;
   localparam logic [15:0] DEF_VEC_BASE   = 16'h0005;
   localparam int          DEF_VEC_STRIDE = 2;

   // Return-stack entry at the default geometry (16-bit PC, four interrupt lines)
   typedef struct packed {
      logic [15:0] pc;
      logic [1:0]  id;
   } stack_entry_t;

endpackage

// File: rtl/fetch_irq_unit_stack.sv
// Return-PC stack for nested interrupts: a LIFO of {pc, irq id} entries.
// Push and pop are mutually exclusive and the caller guarantees no overflow or underflow.
module irq_ret_stack
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = $bits(stack_entry_t),
   localparam int DEPTH_W = $clog2(DEPTH + 1),
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [WIDTH-1:0]   data_i,
   output logic [WIDTH-1:0]   top_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               full_o
);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [IDX_W-1:0]   wrIdx;
   logic [IDX_W-1:0]   rdIdx;

   assign wrIdx   = depth_q[IDX_W-1:0];
   assign rdIdx   = IDX_W'(depth_q - DEPTH_W'(1));
   assign top_o   = mem_q[rdIdx];
   assign depth_o = depth_q;
   assign full_o  = (depth_q == DEPTH_W'(DEPTH));

   always_comb begin
      depth_d = depth_q;
      if (push_i) begin
         depth_d = depth_q + DEPTH_W'(1);
      end else if (pop_i) begin
         depth_d = depth_q - DEPTH_W'(1);
      end
   end

   // Entries are written at the current depth; popping just lowers the depth
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         depth_q <= depth_d;
         if (push_i) begin
            mem_q[wrIdx] <= data_i;
         end
      end
   end

endmodule

// File: rtl/fetch_irq_unit.sv
// Instruction-fetch front end: PC register, next-PC selection and vectored,
// prioritised, nestable interrupts backed by a hardware return-PC stack.
module fetch_irq_unit
   import fetch_pkg::*;
#(
   parameter int              PC_W        = 16,
   parameter int              INSTR_W     = 16,
   parameter int              NUM_IRQ     = 4,
   parameter int              STACK_DEPTH = 4,
   parameter logic [PC_W-1:0] VEC_BASE    = PC_W'(DEF_VEC_BASE),
   parameter int              VEC_STRIDE  = DEF_VEC_STRIDE,
   parameter logic [3:0]      RTI_OPC     = DEF_RTI_OPC,
   localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   output logic [NUM_IRQ-1:0] irq_ack,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt,
   input  logic [PC_W-1:0]    halt_pc,
   input  logic               stall,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    pc_plus1,
   output logic [DEPTH_W-1:0] int_depth,
   output logic               stack_full
);

   logic [PC_W-1:0]      pc_q, pc_d;
   logic [NUM_IRQ-1:0]   irqAck_q, irqAck_d;
   logic [ID_W-1:0]      sel;
   logic [ID_W:0]        curLvl;
   logic [PC_W+ID_W-1:0] pushEntry;
   logic [PC_W+ID_W-1:0] topEntry;
   logic [PC_W-1:0]      topPc;
   logic [ID_W-1:0]      topId;
   logic [PC_W-1:0]      vecPc;
   logic [DEPTH_W-1:0]   depth;
   logic                 full;
   logic                 take;
   logic                 rti;
   logic                 stackPop;

   // Lowest set request index wins
   always_comb begin
      sel = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq[i]) begin
            sel = ID_W'(i);
         end
      end
   end

   assign topPc  = topEntry[ID_W +: PC_W];
   assign topId  = topEntry[ID_W-1:0];
   assign curLvl = (depth == '0) ? (ID_W + 1)'(NUM_IRQ) : {1'b0, topId};

   assign take      = (|irq) && ({1'b0, sel} < curLvl) && !full;
   assign rti       = (imem_rdata[INSTR_W-1 -: 4] == RTI_OPC) && (depth != '0);
   assign stackPop  = rti && !take;
   assign pushEntry = {pc_q, sel};
   assign vecPc     = VEC_BASE + PC_W'(int'(sel) * VEC_STRIDE);

   irq_ret_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_W + ID_W)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .push_i  (take),
      .pop_i   (stackPop),
      .data_i  (pushEntry),
      .top_o   (topEntry),
      .depth_o (depth),
      .full_o  (full)
   );

   // Next-PC priority: take, rti, halt, redirect, stall, sequential.
   // A take pushes the current PC so the discarded fetch is replayed on return.
   always_comb begin
      pc_d     = pc_plus1;
      irqAck_d = '0;
      if (take) begin
         pc_d     = vecPc;
         irqAck_d = NUM_IRQ'(1) << sel;
      end else if (rti) begin
         pc_d = topPc;
      end else if (halt) begin
         pc_d = halt_pc;
      end else if (redirect) begin
         pc_d = redirect_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= '0;
         irqAck_q <= '0;
      end else begin
         pc_q     <= pc_d;
         irqAck_q <= irqAck_d;
      end
   end

   assign pc         = pc_q;
   assign pc_plus1   = pc_q + PC_W'(1);
   assign imem_addr  = pc_q;
   assign instr      = imem_rdata;
   assign irq_ack    = irqAck_q;
   assign int_depth  = depth;
   assign stack_full = full;

endmodule

// File: tb/tb_fetch_irq_unit.sv
// Directed scoreboard bench for fetch_irq_unit: expectations are queued with each
// stimulus step and popped against the DUT outputs after the following clock edge.
module tb_fetch_irq_unit;

   logic        clk;
   logic        rst;
   logic [3:0]  irq;
   logic [3:0]  irq_ack;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic [15:0] halt_pc;
   logic        stall;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic [2:0]  int_depth;
   logic        stack_full;

   typedef struct {
      string       sig;
      logic [31:0] val;
   } exp_t;

   exp_t  sbQ[$];
   int    assertCount = 0;
   int    failCount   = 0;
   string stepName    = "init";

   localparam logic [15:0] RTI = 16'h3000;
   localparam logic [15:0] NOP = 16'h0000;

   fetch_irq_unit dut (
      .clk         (clk),
      .rst         (rst),
      .irq         (irq),
      .irq_ack     (irq_ack),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .halt_pc     (halt_pc),
      .stall       (stall),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .pc          (pc),
      .pc_plus1    (pc_plus1),
      .int_depth   (int_depth),
      .stack_full  (stack_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [3:0] irqV, input logic redirV, input logic [15:0] rpc,
                                input logic haltV, input logic [15:0] hpc, input logic stallV,
                                input logic [15:0] rdata);
      irq         = irqV;
      redirect    = redirV;
      redirect_pc = rpc;
      halt        = haltV;
      halt_pc     = hpc;
      stall       = stallV;
      imem_rdata  = rdata;
   endtask

   task automatic pushExp(input string sig, input logic [31:0] val);
      exp_t e;
      e.sig = sig;
      e.val = val;
      sbQ.push_back(e);
   endtask

   task automatic expState(input logic [15:0] pcV, input int depthV, input logic [3:0] ackV);
      pushExp("pc",    32'(pcV));
      pushExp("addr",  32'(pcV));
      pushExp("depth", 32'(depthV));
      pushExp("ack",   32'(ackV));
      pushExp("full",  (depthV == 4) ? 32'd1 : 32'd0);
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [31:0] obs;
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         case (e.sig)
            "pc":    obs = 32'(pc);
            "addr":  obs = 32'(imem_addr);
            "depth": obs = 32'(int_depth);
            "ack":   obs = 32'(irq_ack);
            "full":  obs = 32'(stack_full);
            "plus1": obs = 32'(pc_plus1);
            "instr": obs = 32'(instr);
            default: obs = 'x;
         endcase
         assertCount++;
         assert (obs === e.val) else begin
            failCount++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", stepName, e.sig, obs, e.val);
         end
      end
   endtask

   task automatic step(input string name);
      stepName = name;
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      repeat (2) @(posedge clk);
      #1;
      stepName = "reset";
      expState(16'h0000, 0, 4'b0000);
      checkOutput();
      rst = 1'b0;

      // Sequential fetch across the wrap point
      applyStimulus(4'b0000, 1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'hFFFE, 0, 4'b0000);
      step("redirFFFE");
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'hFFFF, 0, 4'b0000);
      pushExp("plus1", 32'h0000);
      step("wrapFFFF");
      expState(16'h0000, 0, 4'b0000);
      pushExp("plus1", 32'h0001);
      step("wrap0000");

      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, NOP);
      expState(16'h0000, 0, 4'b0000);
      step("stallHold");
      applyStimulus(4'b0000, 1'b1, 16'h0050, 1'b1, 16'h0030, 1'b0, NOP);
      expState(16'h0030, 0, 4'b0000);
      step("haltOverRedirect");
      applyStimulus(4'b0000, 1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0020, 0, 4'b0000);
      step("redir0020");

      // Single interrupt and return
      applyStimulus(4'b0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0009, 1, 4'b0100);
      step("takeIrq2");
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, RTI);
      expState(16'h0020, 0, 4'b0000);
      pushExp("instr", 32'(RTI));
      step("rtiIrq2");

      // Preemption, held lower-priority request taken after unwinding
      applyStimulus(4'b0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0009, 1, 4'b0100);
      step("takeIrq2Again");
      applyStimulus(4'b0001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0005, 2, 4'b0001);
      step("preemptIrq0");
      applyStimulus(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0006, 2, 4'b0000);
      step("irq3Masked");
      applyStimulus(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, RTI);
      expState(16'h0009, 1, 4'b0000);
      step("rtiToIrq2");
      expState(16'h0020, 0, 4'b0000);
      step("rtiToMain");
      applyStimulus(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h000B, 1, 4'b1000);
      step("heldIrq3Taken");

      // Fill the stack to its full depth
      applyStimulus(4'b0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0009, 2, 4'b0100);
      step("nestIrq2");
      applyStimulus(4'b0010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0007, 3, 4'b0010);
      step("nestIrq1");
      applyStimulus(4'b0001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0005, 4, 4'b0001);
      step("nestIrq0");
      applyStimulus(4'b1111, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0006, 4, 4'b0000);
      step("fullNoTake");
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, RTI);
      expState(16'h0007, 3, 4'b0000);
      step("unwind3");
      expState(16'h0009, 2, 4'b0000);
      step("unwind2");
      expState(16'h000B, 1, 4'b0000);
      step("unwind1");
      expState(16'h0020, 0, 4'b0000);
      step("unwind0");
      expState(16'h0021, 0, 4'b0000);
      step("rtiEmptyStack");

      // Take beats halt, redirect and stall in the same cycle
      applyStimulus(4'b0010, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b1, NOP);
      expState(16'h0007, 1, 4'b0010);
      step("takeOverAll");
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, RTI);
      expState(16'h0021, 0, 4'b0000);
      step("rtiAfterOverride");

      // Take on the same cycle as an RTI pushes the RTI's own address
      applyStimulus(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h000B, 1, 4'b1000);
      step("lvl3Enter");
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h000C, 1, 4'b0000);
      step("lvl3Seq");
      applyStimulus(4'b0010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, RTI);
      expState(16'h0007, 2, 4'b0010);
      step("takeOverRti");
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, RTI);
      expState(16'h000C, 1, 4'b0000);
      step("returnToRti");
      expState(16'h0021, 0, 4'b0000);
      step("rtiReExecuted");

      // Asynchronous reset mid-run
      applyStimulus(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h000B, 1, 4'b1000);
      step("preResetIrq3");
      applyStimulus(4'b0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0009, 2, 4'b0100);
      step("preResetIrq2");
      applyStimulus(4'b0000, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0040, 2, 4'b0000);
      step("preResetRedir");
      #2;
      rst = 1'b1;
      #1;
      stepName = "asyncReset";
      expState(16'h0000, 0, 4'b0000);
      checkOutput();
      rst = 1'b0;

      applyStimulus(4'b1000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h000B, 1, 4'b1000);
      step("ackBeforeReset");
      rst = 1'b1;
      #1;
      stepName = "asyncResetAck";
      expState(16'h0000, 0, 4'b0000);
      checkOutput();
      rst = 1'b0;
      applyStimulus(4'b0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, NOP);
      expState(16'h0001, 0, 4'b0000);
      step("postReset");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fetch_irq_unit.md
Name: fetch_irq_unit

Overview:
Parametrised instruction-fetch front end: holds the PC, selects the next PC and presents the fetched instruction to decode. Adds vectored, prioritised, nestable interrupts with a hardware return-PC stack, replacing the single-vector, single-level scheme. Sits between the instruction memory and decode; redirect, halt and stall come from later pipeline stages.

Parameters:
PC_W, 16, PC and instruction-address width
INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4]
NUM_IRQ, 4, interrupt lines; index 0 is highest priority
STACK_DEPTH, 4, return-stack entries, i.e. maximum nesting depth
VEC_BASE, 16'h0005, PC of the vector for irq 0
VEC_STRIDE, 2, address spacing between consecutive vectors
RTI_OPC, 4'b0011, opcode for return-from-interrupt

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
irq  in  NUM_IRQ  level interrupt requests
irq_ack  out  NUM_IRQ  one-hot, one-cycle pulse in the cycle after an irq is taken
redirect  in  1  branch/jump taken
redirect_pc  in  PC_W  branch/jump target
halt  in  1  halt request
halt_pc  in  PC_W  PC to hold while halted
stall  in  1  load-use stall; hold the PC
imem_addr  out  PC_W  instruction-memory address (= pc)
imem_rdata  in  INSTR_W  combinational read data
instr  out  INSTR_W  = imem_rdata
pc  out  PC_W  current PC
pc_plus1  out  PC_W  pc+1, modulo 2^PC_W
int_depth  out  clog2(STACK_DEPTH+1)  number of valid stack entries
stack_full  out  1  int_depth == STACK_DEPTH

Behaviour:
- Reset (asynchronous): pc=0, stack empty, int_depth=0, irq_ack=0, stack_full=0.
- Current level cur_lvl = irq id of the top stack entry. When the stack is empty, cur_lvl=NUM_IRQ (no interrupt active).
- Winning request sel = lowest set index of irq. take = |irq && sel<cur_lvl && !stack_full.
- rti = (opcode==RTI_OPC) && int_depth!=0. An RTI opcode with an empty stack is an ordinary instruction.
- Next-PC priority, highest first:
  - take: push {pc, sel}; next pc = VEC_BASE + sel*VEC_STRIDE, truncated to PC_W.
  - rti: pop; next pc = popped pc.
  - halt: halt_pc.
  - redirect: redirect_pc.
  - stall: pc.
  - otherwise: pc_plus1.
- The current pc is pushed, not pc+1. The instruction fetched in the take cycle is discarded and re-fetched on return.
- take and rti in the same cycle: take wins and pushes the RTI's own pc, so the RTI re-executes after the nested handler. There is no pop that cycle; depth increases by 1.
- take overrides a simultaneous halt, redirect or stall.
- Equal or lower-priority requests are held off (not acked) until the active level is popped. Requests that are masked or arrive while stack_full receive no ack and are not latched; the source must hold irq.
- irq_ack[sel] is registered from take (1-cycle latency), so it is a single pulse per take.
- Stack: LIFO array of STACK_DEPTH entries of {PC_W-bit pc, clog2(NUM_IRQ)-bit id}. Push and pop never occur in the same cycle. There is no overflow because take is gated by stack_full. There is no underflow because rti is gated by depth!=0.
- pc_plus1 wraps: all-ones → 0.

Decomposition:
- Shared package fetch_pkg: RTI opcode constant, vector base/stride defaults, and a typedef for the stack entry struct {pc, id}.
- One sub-module, irq_ret_stack (LIFO with push, pop, top, depth and full outputs). Priority encoding and the next-PC mux stay in fetch_irq_unit.

Test Plan:
- Reset mid-run with pc=0x0040 and depth=2 → pc=0, depth=0, irq_ack=0 immediately, without waiting for a clock edge.
- Sequential fetch, no events, pc starting at 0xFFFE → pc goes 0xFFFF, then 0x0000.
- irq=4'b0100 at pc=0x0020 → next pc=0x0009, depth=1, irq_ack=4'b0100 one cycle later. Feeding RTI at 0x0009 → pc=0x0020, depth=0.
- In the irq2 handler, assert irq=4'b0001 → preempts to 0x0005, depth=2. Then irq=4'b1000 → no take, no ack. After two RTIs: pc returns to the irq2 handler, then to the original PC.
- Fill the stack to 4 via irq 3,2,1,0 nesting (STACK_DEPTH=4); a further request → no take, and stack_full stays 1. RTI at depth 0 → behaves as PC+1.
- Same cycle: irq=4'b0010 with redirect=1 and halt=1 → vector 0x0007 is taken. Same cycle: RTI with irq1 at lvl3 → take, pushed pc = RTI address, depth increments by 1.
